// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, width helper and detection-mode enum for the sequence detector
package seq_det_pkg;
  localparam int DEF_LEN = 4;
  localparam logic [31:0] DEF_PATTERN = 32'b0110;
  typedef enum logic {MODE_NOOVL = 1'b0, MODE_OVL = 1'b1} mode_e;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear coincident with an increment leaves a count of 1
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= W'(inc);
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with overlap control,
// valid-qualified input, registered match pulse and saturating match counter
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  parameter int DEF_LEN = seq_det_pkg::DEF_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter bit DEF_OVERLAP = 1'b1,
  localparam int LEN_W = seq_det_pkg::len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               x_in,
  input  logic               cfg_we,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic [LEN_W-1:0]   fill_o
);
  import seq_det_pkg::*;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  logic [LEN_W-1:0] len_q, fill_q, fill_next, len_clamp;
  logic [MAX_LEN-1:0] pat_q, hist_q, shifted, mask;
  mode_e mode_q;
  logic match_q, hit;
  // mask = (1<<len)-1, written as an inverted shift so len == MAX_LEN needs no extra bit
  always_comb begin
    shifted = {hist_q[MAX_LEN-2:0], x_in};
    fill_next = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
    mask = ~({MAX_LEN{1'b1}} << len_q);
    len_clamp = (cfg_len > MAX_L) ? MAX_L : cfg_len;
    hit = in_valid && !cfg_we && (len_q != '0) && (fill_next >= len_q) &&
          (((shifted ^ pat_q) & mask) == '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      len_q <= LEN_W'(DEF_LEN);
      pat_q <= DEF_PATTERN;
      mode_q <= mode_e'(DEF_OVERLAP);
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
    end else if (cfg_we) begin
      len_q <= len_clamp;
      pat_q <= cfg_pattern;
      mode_q <= mode_e'(cfg_overlap);
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (in_valid) begin
        hist_q <= shifted;
        fill_q <= (hit && mode_q == MODE_NOOVL) ? '0 : fill_next;
      end
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(hit),
    .clr(cnt_clr),
    .count(match_count_o)
  );
  assign match_o = match_q;
  assign fill_o = fill_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial sequence detector: the next-generation replacement for the fixed "0110" Moore detector. It matches any pattern of 1..MAX_LEN bits, supports overlapping and non-overlapping detection, qualifies input bits with a valid strobe, and keeps a saturating match counter. It sits between a serial bit source and control/status logic, and is configured through a simple write port.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be at least 2.
- CNT_W, 16: width of the match counter.
- DEF_LEN, 4: pattern length after reset.
- DEF_PATTERN, 'b0110: pattern after reset, right-aligned, MAX_LEN bits.
- DEF_OVERLAP, 1: overlap mode after reset.
- LEN_W: derived, $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  x_in is sampled on this edge when high.
- x_in  in  1  serial data bit.
- cfg_we  in  1  configuration write strobe.
- cfg_len  in  LEN_W  pattern length.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of the match counter.
- match_o  out  1  one-cycle match pulse, registered.
- match_count_o  out  CNT_W  saturating count of matches.
- fill_o  out  LEN_W  number of bits held in the history that are eligible for a match.

## Operation
- Reset values: history = 0, fill_o = 0, match_o = 0, match_count_o = 0, len = DEF_LEN, pattern = DEF_PATTERN, overlap = DEF_OVERLAP.
- History is a MAX_LEN-bit shift register. On an accepted bit: hist <= {hist[MAX_LEN-2:0], x_in}. The newest bit is at hist[0].
- Fill counter:
  - Increments on each accepted bit and saturates at MAX_LEN.
  - On a match in non-overlap mode, fill is set to 0 instead.
- Match condition, evaluated on the accepted bit including that bit:
  - len != 0, and
  - fill_next >= len (fill_next is the fill value before any non-overlap clear), and
  - {hist[len-2:0], x_in} == pattern[len-1:0].
- The match condition sets match_o on that edge; otherwise match_o is cleared on every edge.
- Overlap mode: the history is retained after a match. For example, "0110110" with pattern 0110 gives two matches.
- Non-overlap mode: a match restarts eligibility, so the next match needs len fresh bits.
- Length handling:
  - len = 0 disables detection; the history and fill still update.
  - cfg_len > MAX_LEN is clamped to MAX_LEN when written.
- Configuration write (cfg_we = 1):
  - Latches len, pattern and overlap.
  - Clears history and fill.
  - Clears match_o on the same edge.
  - An in_valid bit on the same edge is discarded.
- Match counter:
  - Increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr together with a match on the same edge gives a result of 1.
  - cnt_clr alone gives 0.
- in_valid = 0: history, fill and counter hold; match_o drops to 0.

## Timing
- Latency: match_o rises in the cycle after the edge that samples the final pattern bit. This is Moore-style: it is never combinational from x_in.
- match_o is high for exactly one cycle per match. Back-to-back pulses occur only when consecutive accepted bits each complete a match in overlap mode (e.g. pattern 11 on 111).
- match_count_o updates on the same edge as match_o.
- A new configuration applies to the first bit accepted after the cfg_we edge.
- Reset asserted mid-sequence clears everything asynchronously. The first post-reset match needs len fresh bits.

## Structure
- Shared package seq_det_pkg holds:
  - the default constants DEF_LEN and DEF_PATTERN = 'b0110;
  - the LEN_W derivation helper;
  - a mode enum {MODE_NOOVL = 0, MODE_OVL = 1}.
- Sub-module sat_counter (parameter W, with inc and clr inputs) implements the saturating match counter with the clr+inc priority defined above.
- The pattern comparator is a masked compare: mask = (1<<len)-1, applied to both sides.

## Test plan
- Reset defaults, overlap on, stream 0,1,1,0,1,1,0 → match_o pulses in the cycle after bit 4 and after bit 7; match_count_o = 2.
- Same stream with overlap = 0 (written via cfg_we) → single pulse after bit 4; match_count_o = 1.
- Configure len = 3, pattern = 101, overlap on, stream 1,0,1,0,1 → pulses after bits 3 and 5. Then write len = 0 → no pulses on any stream.
- Configure len = 2, pattern = 11, stream 1,1,1,1 with in_valid gaps between bits → one pulse per accepted bit from bit 2 onward; match_o is 0 during gaps; fill_o holds.
- CNT_W = 2, run 5 matches → count saturates at 3. Assert cnt_clr together with a match → count = 1. cnt_clr alone → 0.
- Assert reset after 0,1,1 then send 0 → no match. cfg_we coincident with the completing bit → no match, fill_o = 0. cfg_len = 15 with MAX_LEN = 8 → len reads back as behaving like 8.
